// File: rtl/iccm_ctrl_pkg.sv
// iccm_ctrl_pkg: shared types and constants for the ICCM boot loader.
package iccm_ctrl_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        DONE = 1'b1
    } iccm_ctrl_state_e;

    localparam logic [31:0] ICCM_END_WORD = 32'h0000_0FFF;

endpackage

// File: rtl/iccm_ctrl_if.sv
// iccm_ctrl_if: write-only port from the boot loader into the ICCM controller.
interface iccm_ctrl_if #(
    parameter int unsigned AddrW = 12
);
    logic [AddrW-1:0] iccm_ctrl_addr;
    logic [31:0]      iccm_ctrl_wdata;
    logic             iccm_ctrl_we;

    modport master (
        output iccm_ctrl_addr,
        output iccm_ctrl_wdata,
        output iccm_ctrl_we
    );

    modport slave (
        input iccm_ctrl_addr,
        input iccm_ctrl_wdata,
        input iccm_ctrl_we
    );
endinterface

// File: rtl/iccm_ctrl.sv
// iccm_ctrl: assembles UART bytes into little-endian ICCM words and holds the core in reset
// until the end marker arrives or memory fills. Define ICCM_CTRL_TIMEOUT_EN for inter-byte timeout.
module iccm_ctrl
    import iccm_ctrl_pkg::*;
#(
    parameter int unsigned AddrW         = 12,
    parameter logic [31:0] EndWord       = ICCM_END_WORD,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [7:0]     rx_byte_i,
    input  logic           rx_valid_i,
    input  logic           prog_req_i,
    iccm_ctrl_if.master    iccm,
    output logic           prog_rst_ni,
    output logic           full_o,
    output logic [AddrW:0] word_cnt_o
);

    iccm_ctrl_state_e state;
    logic [1:0]       byte_cnt;
    logic [31:0]      asm_q;
    logic [AddrW-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [31:0]      word;
    logic             timeout;

    assign word = {rx_byte_i, asm_q[31:8]};

    assign iccm.iccm_ctrl_addr  = addr_q;
    assign iccm.iccm_ctrl_wdata = wdata_q;
    assign iccm.iccm_ctrl_we    = we_q;

`ifdef ICCM_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);

    logic [TW-1:0] idle_cnt;

    assign timeout = (state == LOAD) && (byte_cnt != 2'd0) &&
                     (idle_cnt == TW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || state != LOAD || rx_valid_i || byte_cnt == 2'd0 || timeout) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign timeout = 1'b0 && (TimeoutCycles != 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= LOAD;
            byte_cnt    <= '0;
            asm_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            prog_rst_ni <= 1'b0;
            full_o      <= 1'b0;
            word_cnt_o  <= '0;
        end else begin
            // Write completion runs alongside byte assembly; words are >= 4 cycles apart.
            if (we_q) begin
                we_q       <= 1'b0;
                word_cnt_o <= word_cnt_o + (AddrW + 1)'(1);
                if (addr_q == '1) begin
                    state       <= DONE;
                    full_o      <= 1'b1;
                    prog_rst_ni <= 1'b1;
                end else begin
                    addr_q <= addr_q + AddrW'(1);
                end
            end

            case (state)
                LOAD: begin
                    if (rx_valid_i) begin
                        if (timeout) begin
                            asm_q    <= {rx_byte_i, 24'h0};
                            byte_cnt <= 2'd1;
                        end else begin
                            asm_q    <= word;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                if (word == EndWord) begin
                                    state       <= DONE;
                                    prog_rst_ni <= 1'b1;
                                end else begin
                                    wdata_q <= word;
                                    we_q    <= 1'b1;
                                end
                            end
                        end
                    end else if (timeout) begin
                        byte_cnt <= '0;
                        asm_q    <= '0;
                    end
                end
                DONE: begin
                    if (prog_req_i) begin
                        state       <= LOAD;
                        prog_rst_ni <= 1'b0;
                        addr_q      <= '0;
                        byte_cnt    <= '0;
                        asm_q       <= '0;
                        word_cnt_o  <= '0;
                        full_o      <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_iccm_ctrl.sv
// tb_iccm_ctrl: randomized and directed stimulus checked cycle-by-cycle against a byte-queue model.
module tb_iccm_ctrl;
    import iccm_ctrl_pkg::*;

    localparam int unsigned AW    = 3;
    localparam int unsigned MAXA  = (1 << AW) - 1;
    localparam int unsigned TO    = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [7:0]    rx_byte_i;
    logic          rx_valid_i;
    logic          prog_req_i;
    logic          prog_rst_ni;
    logic          full_o;
    logic [AW:0]   word_cnt_o;

    iccm_ctrl_if #(.AddrW(AW)) iccm ();

    iccm_ctrl #(
        .AddrW(AW),
        .EndWord(ICCM_END_WORD),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .rx_byte_i(rx_byte_i),
        .rx_valid_i(rx_valid_i),
        .prog_req_i(prog_req_i),
        .iccm(iccm),
        .prog_rst_ni(prog_rst_ni),
        .full_o(full_o),
        .word_cnt_o(word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    bit          armed    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: current expected outputs, advanced once per clock edge.
    logic [7:0]  m_bytes[$];
    bit          m_done, m_we, m_prog, m_full;
    int unsigned m_addr, m_wc, m_idle;
    logic [31:0] m_wdata;

    task automatic model_edge(input bit v, input logic [7:0] b, input bit q, input bit r);
        bit          was_done;
        logic [31:0] w;
        if (!r) begin
            m_bytes.delete();
            m_done = 0; m_we = 0; m_prog = 0; m_full = 0;
            m_addr = 0; m_wc = 0; m_idle = 0; m_wdata = '0;
            return;
        end
        was_done = m_done;
        if (m_we) begin
            m_we = 0;
            m_wc++;
            if (m_addr == MAXA) begin
                m_done = 1; m_full = 1; m_prog = 1;
            end else begin
                m_addr++;
            end
        end
        if (was_done) begin
            if (q) begin
                m_done = 0; m_prog = 0; m_full = 0;
                m_addr = 0; m_wc = 0; m_idle = 0;
                m_bytes.delete();
            end
        end else begin
`ifdef ICCM_CTRL_TIMEOUT_EN
            if (m_bytes.size() != 0 && m_idle == TO - 1) m_bytes.delete();
`endif
            if (v) begin
                m_idle = 0;
                m_bytes.push_back(b);
                if (m_bytes.size() == 4) begin
                    w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_bytes.delete();
                    if (w == ICCM_END_WORD) begin
                        m_done = 1; m_prog = 1;
                    end else begin
                        m_we = 1; m_wdata = w;
                    end
                end
            end else if (m_bytes.size() != 0) begin
                m_idle++;
            end else begin
                m_idle = 0;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (armed) begin
            check("we", {31'd0, iccm.iccm_ctrl_we}, {31'd0, m_we});
            check("addr", {29'd0, iccm.iccm_ctrl_addr}, m_addr);
            if (m_we) check("wdata", iccm.iccm_ctrl_wdata, m_wdata);
            check("prog_rst", {31'd0, prog_rst_ni}, {31'd0, m_prog});
            check("full", {31'd0, full_o}, {31'd0, m_full});
            check("word_cnt", {28'd0, word_cnt_o}, m_wc);
        end
    end

    task automatic tick(input bit v, input logic [7:0] b, input bit q, input bit r);
        rx_valid_i = v;
        rx_byte_i  = b;
        prog_req_i = q;
        rst_ni     = r;
        @(posedge clk_i);
        model_edge(v, b, q, r);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned gap);
        for (int unsigned i = 0; i < 4; i++) begin
            tick(1'b1, w[8*i +: 8], 1'b0, 1'b1);
            idle(gap);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == ICCM_END_WORD) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        rx_valid_i = 1'b0; rx_byte_i = '0; prog_req_i = 1'b0; rst_ni = 1'b0;
        @(posedge clk_i); #1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        armed = 1'b1;
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_addr", {29'd0, iccm.iccm_ctrl_addr}, 32'd0);
        check("rst_prog", {31'd0, prog_rst_ni}, 32'd0);

        send_word(32'h0000_0013, 1);
        send_word(32'h0010_0093, 1);
        idle(3);
        check("two_words_cnt", {28'd0, word_cnt_o}, 32'd2);
        check("two_words_prog", {31'd0, prog_rst_ni}, 32'd0);

        send_word(ICCM_END_WORD, 0);
        check("marker_prog", {31'd0, prog_rst_ni}, 32'd1);
        send_word(rand_word(), 0);
        idle(3);
        check("done_ignore_cnt", {28'd0, word_cnt_o}, 32'd2);

        tick(1'b0, 8'h00, 1'b1, 1'b1);
        check("reprog_prog", {31'd0, prog_rst_ni}, 32'd0);
        for (int unsigned k = 0; k < 8; k++) send_word(rand_word(), 0);
        idle(2);
        check("fill_full", {31'd0, full_o}, 32'd1);
        check("fill_prog", {31'd0, prog_rst_ni}, 32'd1);
        check("fill_addr", {29'd0, iccm.iccm_ctrl_addr}, MAXA);
        send_word(rand_word(), 0);
        idle(2);
        check("ninth_cnt", {28'd0, word_cnt_o}, 32'd8);

        tick(1'b0, 8'h00, 1'b1, 1'b1);
        send_word(rand_word(), 1);
        idle(2);
        check("reprog_full", {31'd0, full_o}, 32'd0);
        check("reprog_cnt", {28'd0, word_cnt_o}, 32'd1);

        tick(1'b1, 8'hAA, 1'b0, 1'b1);
        tick(1'b1, 8'hBB, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        w = 32'hCAFE_F00D;
        send_word(w, 0);
        idle(2);
        check("midrst_data", iccm.iccm_ctrl_wdata, w);
        check("midrst_addr", {29'd0, iccm.iccm_ctrl_addr}, 32'd1);

`ifdef ICCM_CTRL_TIMEOUT_EN
        tick(1'b1, 8'h11, 1'b0, 1'b1);
        tick(1'b1, 8'h22, 1'b0, 1'b1);
        idle(TO);
        w = 32'h1234_5678;
        send_word(w, 0);
        idle(2);
        check("timeout_data", iccm.iccm_ctrl_wdata, w);
        check("timeout_cnt", {28'd0, word_cnt_o}, 32'd2);
`else
        tick(1'b1, 8'h78, 1'b0, 1'b1);
        tick(1'b1, 8'h56, 1'b0, 1'b1);
        idle(40);
        tick(1'b1, 8'h34, 1'b0, 1'b1);
        tick(1'b1, 8'h12, 1'b0, 1'b1);
        idle(2);
        check("wait_data", iccm.iccm_ctrl_wdata, 32'h1234_5678);
        check("wait_cnt", {28'd0, word_cnt_o}, 32'd2);
`endif

        for (int unsigned c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 1) == 1, 8'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 299) != 0);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/iccm_ctrl.md
# iccm_ctrl

Boot-time ICCM loader sitting directly upstream of the instruction-memory top. It takes a byte stream from the UART receiver, assembles little-endian 32-bit instruction words, writes them to consecutive ICCM word addresses over the ICCM controller write port, and holds the core's program reset low until an end-of-program marker arrives or the memory is full. A reprogram request returns it to loading mode.

## Interface
- `AddrW`, 12: ICCM word-address width.
- `EndWord`, 32'h0000_0FFF: end-of-program marker word. It is never written.
- `TimeoutCycles`, 1_000_000: inter-byte timeout. Used only under the macro.
- `clk_i` in 1: clock.
- `rst_ni` in 1: synchronous active-low reset. One clock; reset is synchronous and active-low.
- `rx_byte_i` in 8: received byte.
- `rx_valid_i` in 1: one-cycle strobe. `rx_byte_i` is valid in that cycle.
- `prog_req_i` in 1: level. Requests reprogramming when in DONE.
- `iccm_ctrl_addr` out AddrW: write word address.
- `iccm_ctrl_wdata` out 32: write data.
- `iccm_ctrl_we` out 1: active-high write strobe, one cycle per word.
- `prog_rst_ni` out 1: 0 while loading; 1 when the program is complete and the core may run.
- `full_o` out 1: sticky. Loading ended because the address space was exhausted.
- `word_cnt_o` out AddrW+1: number of words written in the current load.

## Operation
- FSM states:
  - LOAD: accumulate bytes and issue writes.
  - DONE: release the core; ignore bytes.
- Reset values:
  - state=LOAD, byte_cnt=0, asm=0.
  - `iccm_ctrl_addr`=0, `iccm_ctrl_wdata`=0, `iccm_ctrl_we`=0.
  - `prog_rst_ni`=0, `full_o`=0, `word_cnt_o`=0.
- LOAD, on `rx_valid_i`:
  - asm <= {rx_byte_i, asm[31:8]}. The first byte received is bits [7:0].
  - byte_cnt increments mod 4.
- On acceptance of the 4th byte, form word w = {rx_byte_i, asm[31:8]}:
  - If w == `EndWord`: go to DONE; no write.
  - Otherwise: next edge `iccm_ctrl_wdata`=w, `iccm_ctrl_we`=1, and `iccm_ctrl_addr` holds the current write address.
  - The edge after that: `iccm_ctrl_we`=0, address increments, `word_cnt_o` increments.
- Full condition: a write completes to address 2^AddrW-1. Then go to DONE and set `full_o`=1. The address does not wrap.
- Byte acceptance is independent of the write pipeline. A byte arriving during the `iccm_ctrl_we` cycle is assembled normally. Word writes are therefore at least 4 cycles apart.
- DONE:
  - `prog_rst_ni`=1; `rx_valid_i` is ignored.
  - `prog_rst_ni` rises on the edge that enters DONE. It rises one cycle after the final write strobe when loading ends on full.
- DONE with `prog_req_i`=1:
  - Next edge: state=LOAD, `prog_rst_ni`=0.
  - Address, byte_cnt, asm, `word_cnt_o` and `full_o` are cleared.
- Reset mid-load discards any partial word and restarts at address 0.

## Timing
- Latency from 4th-byte strobe to `iccm_ctrl_we` high is 1 cycle.
- `iccm_ctrl_we` is high for exactly 1 cycle.
- `iccm_ctrl_addr` and `iccm_ctrl_wdata` are stable for the whole `iccm_ctrl_we` cycle. They change only on the edge after it.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The memory is write-only from this block; it expects no response.
- `rx_valid_i` and `prog_req_i` asserted together in LOAD: the byte is processed and the request is ignored.

## Configuration
- `ICCM_CTRL_TIMEOUT_EN` defined:
  - A counter runs in LOAD while byte_cnt≠0. It resets on every `rx_valid_i`.
  - Reaching `TimeoutCycles` discards the partial word: byte_cnt=0, asm=0. Address and `word_cnt_o` are unchanged.
  - A byte arriving on the same cycle as the timeout is taken as byte 0 of a new word.
- Undefined: no counter; a partial word waits indefinitely.

## Structure
- Package `iccm_ctrl_pkg`:
  - state enum `iccm_ctrl_state_e` (LOAD, DONE).
  - `ICCM_END_WORD` constant, the default for `EndWord`.
- Single module, no sub-modules. The timeout counter is an inline `ifdef` block.

## Test plan
- Bytes 13,00,00,00 then 93,00,10,00 → writes 0x00000013 @0 and 0x00100093 @1, each `iccm_ctrl_we` 1 cycle; `word_cnt_o`=2; `prog_rst_ni` stays 0.
- Then bytes FF,0F,00,00 → no write; `prog_rst_ni`=1 one cycle after the last strobe; later bytes cause no writes.
- Back-to-back bytes every cycle for 8 words → 8 writes at addresses 0..7; a byte arriving during each `iccm_ctrl_we` cycle is preserved (check data).
- With AddrW=3, stream 8 non-marker words → last write @7, then `full_o`=1 and `prog_rst_ni`=1; the 9th word is ignored.
- In DONE, pulse `prog_req_i` → `prog_rst_ni`=0, next word written @0, `full_o`=0; `rst_ni` low after 2 bytes then 4 new bytes → single write @0 with only the new bytes.
- With `ICCM_CTRL_TIMEOUT_EN` and TimeoutCycles=16: 2 bytes, idle 16 cycles, then 4 bytes → one write containing only the last 4 bytes.
